// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller.
// Each digit owns a slot of DIV clocks; the first GAP clocks of a slot keep all
// anodes off (ghosting guard) while the hex code is already presented. New
// display contents are staged in a pending register and committed only at the
// 7->0 digit wrap so a frame never shows a mix of old and new data.
module display_scan_ctrl #(
    parameter int DIV = 100000,
    parameter int GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    input  logic        load,
    output logic        ack,
    output logic [7:0]  an,
    output logic [3:0]  code,
    output logic        dp_n,
    output logic        frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Scan position and FSM state
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    state_t        r_state;

    // Displayed and pending content
    logic [31:0]   r_disp_data;
    logic [7:0]    r_disp_dp;
    logic [7:0]    r_disp_blank;
    logic [31:0]   r_pend_data;
    logic [7:0]    r_pend_dp;
    logic [7:0]    r_pend_blank;
    logic          r_pend_valid;

    // Output registers
    logic [7:0]    r_an;
    logic [3:0]    r_code;
    logic          r_dp_n;
    logic          r_ack;
    logic          r_frame;

    // Next-cycle values
    logic          w_wrap;
    logic          w_commit_edge;
    logic          w_do_commit;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    state_t        w_state_next;
    logic [31:0]   w_disp_data_next;
    logic [7:0]    w_disp_dp_next;
    logic [7:0]    w_disp_blank_next;
    logic [7:0]    w_an_next;
    logic [3:0]    w_code_next;
    logic          w_dp_n_next;

    // Slot counter / digit index sequencing and commit qualification
    always_comb begin
        w_wrap        = (r_cnt == CW'(DIV - 1));
        w_commit_edge = w_wrap && (r_idx == 3'd7);
        w_do_commit   = w_commit_edge && r_pend_valid;
        if (w_wrap) begin
            w_cnt_next = {CW{1'b0}};
            w_idx_next = r_idx + 3'd1;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
            w_idx_next = r_idx;
        end
    end

    // FSM next state: blanking gap at slot start, then drive until the wrap
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_GAP: begin
                if (r_cnt == CW'(GAP - 1)) begin
                    w_state_next = ST_DRIVE;
                end else begin
                    w_state_next = ST_GAP;
                end
            end
            ST_DRIVE: begin
                if (w_wrap) begin
                    w_state_next = ST_GAP;
                end else begin
                    w_state_next = ST_DRIVE;
                end
            end
            default: w_state_next = ST_GAP;
        endcase
    end

    // Content that will be displayed after this edge (pending copies in at commit)
    always_comb begin
        if (w_do_commit) begin
            w_disp_data_next  = r_pend_data;
            w_disp_dp_next    = r_pend_dp;
            w_disp_blank_next = r_pend_blank;
        end else begin
            w_disp_data_next  = r_disp_data;
            w_disp_dp_next    = r_disp_dp;
            w_disp_blank_next = r_disp_blank;
        end
    end

    // Output decode from next state/index so outputs move with the state edge
    always_comb begin
        w_an_next   = 8'hFF;
        w_dp_n_next = 1'b1;
        w_code_next = w_disp_data_next[{w_idx_next, 2'b00} +: 4];
        if ((w_state_next == ST_DRIVE) && !w_disp_blank_next[w_idx_next]) begin
            w_an_next   = ~(8'h01 << w_idx_next);
            w_dp_n_next = ~w_disp_dp_next[w_idx_next];
        end else begin
            w_an_next   = 8'hFF;
            w_dp_n_next = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_GAP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
            r_idx <= 3'd0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

    // Pending register: latest load wins; a load on the commit edge re-arms it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_data  <= 32'h0000_0000;
            r_pend_dp    <= 8'h00;
            r_pend_blank <= 8'h00;
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pend_valid <= 1'b1;
        end else if (w_do_commit) begin
            r_pend_valid <= 1'b0;
        end else begin
            r_pend_valid <= r_pend_valid;
        end
    end

    // Displayed register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_data  <= 32'h0000_0000;
            r_disp_dp    <= 8'h00;
            r_disp_blank <= 8'h00;
        end else begin
            r_disp_data  <= w_disp_data_next;
            r_disp_dp    <= w_disp_dp_next;
            r_disp_blank <= w_disp_blank_next;
        end
    end

    // Registered outputs; frame and ack both mark the first cycle of digit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= 8'hFF;
            r_code  <= 4'h0;
            r_dp_n  <= 1'b1;
            r_ack   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_next;
            r_code  <= w_code_next;
            r_dp_n  <= w_dp_n_next;
            r_ack   <= w_do_commit;
            r_frame <= w_commit_edge;
        end
    end

    assign an    = r_an;
    assign code  = r_code;
    assign dp_n  = r_dp_n;
    assign ack   = r_ack;
    assign frame = r_frame;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl with DIV=8, GAP=2 (64-clock frame).
module tb_display_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        load;
    logic        ack;
    logic [7:0]  an;
    logic [3:0]  code;
    logic        dp_n;
    logic        frame;

    int checks;
    int failures;

    display_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .load     (load),
        .ack      (ack),
        .an       (an),
        .code     (code),
        .dp_n     (dp_n),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        int          digit;
        logic [3:0]  exp_code;
        logic [7:0]  exp_an;
        logic        exp_dp_n;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
        data_in  = d;
        dp_in    = p;
        blank_in = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int k;
        k = 0;
        while (frame !== 1'b1 && k < 2 * FRAME) begin
            step();
            k++;
        end
        chk(name, {31'd0, frame}, 32'd1);
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        while (ack !== 1'b1 && k < 2 * FRAME) begin
            step();
            k++;
        end
        chk(name, {31'd0, ack}, 32'd1);
    endtask

    // Called at the frame cycle (slot 0, count 0); ends at count DIV-1 of slot d.
    task automatic check_slot(input int d, input logic [3:0] c, input logic [7:0] a,
                              input logic dpn, input string name);
        repeat (d * DIV) step();
        chk({name, "_gap_an"},   {24'd0, an},   32'h0000_00FF);
        chk({name, "_gap_code"}, {28'd0, code}, {28'd0, c});
        chk({name, "_gap_dpn"},  {31'd0, dp_n}, 32'd1);
        repeat (GAP) step();
        for (int k = GAP; k < DIV; k++) begin
            chk({name, "_an"},   {24'd0, an},   {24'd0, a});
            chk({name, "_code"}, {28'd0, code}, {28'd0, c});
            chk({name, "_dpn"},  {31'd0, dp_n}, {31'd0, dpn});
            if (k < DIV - 1) step();
        end
    endtask

    // Free-running scan after reset release with zero content
    task automatic check_scan_from_reset(input string name, input int cycles);
        logic [7:0] exp_an;
        int         cnt;
        int         idx;
        for (int n = 0; n <= cycles; n++) begin
            cnt = n % DIV;
            idx = (n / DIV) % 8;
            exp_an = (cnt < GAP) ? 8'hFF : ~(8'h01 << idx);
            chk({name, "_an"},    {24'd0, an},    {24'd0, exp_an});
            chk({name, "_frame"}, {31'd0, frame}, {31'd0, (n > 0 && cnt == 0 && idx == 0)});
            chk({name, "_ack"},   {31'd0, ack},   32'd0);
            chk({name, "_code"},  {28'd0, code},  32'd0);
            chk({name, "_dpn"},   {31'd0, dp_n},  32'd1);
            if (n < cycles) step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] cur_d;
        logic [7:0]  cur_p;
        logic [7:0]  cur_b;
        bit          have;
        int          acks;

        checks   = 0;
        failures = 0;
        have     = 1'b0;
        cur_d    = 32'd0;
        cur_p    = 8'd0;
        cur_b    = 8'd0;

        vecs[0] = '{32'h7654_3210, 8'h01, 8'h00, 0, 4'h0, 8'hFE, 1'b0};
        vecs[1] = '{32'h7654_3210, 8'h01, 8'h00, 1, 4'h1, 8'hFD, 1'b1};
        vecs[2] = '{32'h7654_3210, 8'h01, 8'h00, 3, 4'h3, 8'hF7, 1'b1};
        vecs[3] = '{32'h7654_3210, 8'h01, 8'h00, 7, 4'h7, 8'h7F, 1'b1};
        vecs[4] = '{32'h89AB_CDEF, 8'h80, 8'h80, 7, 4'h8, 8'hFF, 1'b1};
        vecs[5] = '{32'h89AB_CDEF, 8'h80, 8'h80, 6, 4'h9, 8'hBF, 1'b1};
        vecs[6] = '{32'h89AB_CDEF, 8'h80, 8'h80, 0, 4'hF, 8'hFE, 1'b1};
        vecs[7] = '{32'h1234_5678, 8'hAA, 8'h00, 1, 4'h7, 8'hFD, 1'b0};
        vecs[8] = '{32'h1234_5678, 8'hAA, 8'h00, 2, 4'h6, 8'hFB, 1'b1};
        vecs[9] = '{32'h1234_5678, 8'hAA, 8'h00, 0, 4'h8, 8'hFE, 1'b1};

        rst      = 1'b1;
        load     = 1'b0;
        data_in  = 32'd0;
        dp_in    = 8'd0;
        blank_in = 8'd0;

        // Reset values
        repeat (3) step();
        chk("rst_an",    {24'd0, an},    32'h0000_00FF);
        chk("rst_code",  {28'd0, code},  32'd0);
        chk("rst_dpn",   {31'd0, dp_n},  32'd1);
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_frame", {31'd0, frame}, 32'd0);

        // Scan pattern: FF x2, FE x6, FF x2, FD ... back to FE after 64 clocks
        rst = 1'b0;
        check_scan_from_reset("scan", FRAME + 2);

        // Table of committed contents and per-digit expectations
        for (int i = 0; i < 10; i++) begin
            if (!have || vecs[i].data != cur_d || vecs[i].dp != cur_p || vecs[i].blank != cur_b) begin
                do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
                wait_ack("vec_ack");
                chk("vec_ack_frame", {31'd0, frame}, 32'd1);
                cur_d = vecs[i].data;
                cur_p = vecs[i].dp;
                cur_b = vecs[i].blank;
                have  = 1'b1;
            end else begin
                wait_frame("vec_frame");
            end
            check_slot(vecs[i].digit, vecs[i].exp_code, vecs[i].exp_an, vecs[i].exp_dp_n, "vec");
        end

        // Two loads in one frame: one ack, latest data shown
        wait_frame("dbl_frame");
        repeat (3) step();
        do_load(32'h0000_00A5, 8'h00, 8'h00);
        repeat (10) step();
        do_load(32'h0000_00B6, 8'h00, 8'h00);
        acks = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (ack === 1'b1) begin
                acks++;
                chk("dbl_ack_code", {28'd0, code}, 32'h6);
            end
            step();
        end
        chk("dbl_ack_count", acks, 32'd1);
        wait_frame("dbl_frame2");
        check_slot(0, 4'h6, 8'hFE, 1'b1, "dbl_d0");

        // Load on the commit edge while another load is pending
        wait_frame("ce_frame");
        repeat (5) step();
        do_load(32'h1111_1111, 8'h00, 8'h00);
        repeat (57) step();
        data_in  = 32'h2222_2222;
        dp_in    = 8'h00;
        blank_in = 8'h00;
        load     = 1'b1;
        step();
        load     = 1'b0;
        chk("ce_ack1",   {31'd0, ack},   32'd1);
        chk("ce_frame1", {31'd0, frame}, 32'd1);
        chk("ce_code1",  {28'd0, code},  32'h1);
        check_slot(3, 4'h1, 8'hF7, 1'b1, "ce_a_d3");
        wait_ack("ce_ack2");
        chk("ce_frame2", {31'd0, frame}, 32'd1);
        chk("ce_code2",  {28'd0, code},  32'h2);
        check_slot(5, 4'h2, 8'hDF, 1'b1, "ce_c_d5");

        // Reset during digit 3 drive with a load pending
        wait_frame("mr_frame");
        repeat (2) step();
        do_load(32'h3333_3333, 8'hFF, 8'h00);
        repeat (25) step();
        chk("mr_pre_an", {24'd0, an}, 32'h0000_00F7);
        rst = 1'b1;
        #1;
        chk("mr_async_an",   {24'd0, an},   32'h0000_00FF);
        chk("mr_async_code", {28'd0, code}, 32'd0);
        step();
        chk("mr_hold_an",    {24'd0, an},    32'h0000_00FF);
        chk("mr_hold_dpn",   {31'd0, dp_n},  32'd1);
        chk("mr_hold_ack",   {31'd0, ack},   32'd0);
        chk("mr_hold_frame", {31'd0, frame}, 32'd0);
        rst = 1'b0;
        check_scan_from_reset("mr_scan", 2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
